// File: rtl/traffic_light_fsm.sv
`timescale 1ns/1ps
// traffic_light_fsm: Moore sequencer for a main/side road junction with a
// pedestrian phase. All phase timing is counted in divider ticks; lamp outputs
// are registered and decoded from the next state so they switch together with
// the state register.
module traffic_light_fsm #(
    parameter int GREEN_MAIN = 8,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 1,
    parameter int GREEN_SIDE = 5,
    parameter int WALK       = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED1   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED2   = 3'd5,
        PED    = 3'd6
    } state_e;

    // Lamp codes, bit order {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Counter load values: the counter holds "ticks left minus one".
    localparam logic [CNT_W-1:0] LD_GREEN_MAIN = CNT_W'(GREEN_MAIN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_SIDE = CNT_W'(GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] LD_WALK       = CNT_W'(WALK - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    // Duration reload for the state being entered.
    function automatic logic [CNT_W-1:0] load_value(input state_e s);
        logic [CNT_W-1:0] v;
        case (s)
            MAIN_G:  v = LD_GREEN_MAIN;
            MAIN_Y:  v = LD_YELLOW;
            RED1:    v = LD_ALL_RED;
            SIDE_G:  v = LD_GREEN_SIDE;
            SIDE_Y:  v = LD_YELLOW;
            RED2:    v = LD_ALL_RED;
            PED:     v = LD_WALK;
            default: v = LD_GREEN_MAIN;
        endcase
        return v;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic [2:0]       main_light_q, main_light_d;
    logic [2:0]       side_light_q, side_light_d;
    logic             walk_q, walk_d;
    logic             expire_s;
    logic             entering_s;

    // Next-state, phase counter, pedestrian latch and lamp decode of the next state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ped_pending_d = ped_pending_q;
        main_light_d  = LAMP_RED;
        side_light_d  = LAMP_RED;
        walk_d        = 1'b0;

        expire_s = tick && (cnt_q == CNT_ZERO);

        if (tick && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            MAIN_G: begin
                // Counter parks at zero; leave only when a request meets a tick.
                if (expire_s && (side_req || ped_pending_q)) state_d = MAIN_Y;
                else                                         state_d = MAIN_G;
            end
            MAIN_Y: begin
                if (expire_s) state_d = RED1;
                else          state_d = MAIN_Y;
            end
            RED1: begin
                if (expire_s) state_d = ped_pending_q ? PED : SIDE_G;
                else          state_d = RED1;
            end
            PED: begin
                if (expire_s) state_d = side_req ? SIDE_G : RED2;
                else          state_d = PED;
            end
            SIDE_G: begin
                if (expire_s) state_d = SIDE_Y;
                else          state_d = SIDE_G;
            end
            SIDE_Y: begin
                if (expire_s) state_d = RED2;
                else          state_d = SIDE_Y;
            end
            RED2: begin
                if (expire_s) state_d = MAIN_G;
                else          state_d = RED2;
            end
            default: state_d = MAIN_G; // encoding 7 recovers to main green
        endcase

        entering_s = (state_d != state_q);
        if (entering_s) cnt_d = load_value(state_d);
        else            cnt_d = cnt_d;

        // A press on the PED entry edge survives the clear and is served next cycle.
        if (ped_req)                              ped_pending_d = 1'b1;
        else if (entering_s && (state_d == PED))  ped_pending_d = 1'b0;
        else                                      ped_pending_d = ped_pending_q;

        case (state_d)
            MAIN_G: begin main_light_d = LAMP_GREEN;  side_light_d = LAMP_RED;    end
            MAIN_Y: begin main_light_d = LAMP_YELLOW; side_light_d = LAMP_RED;    end
            SIDE_G: begin main_light_d = LAMP_RED;    side_light_d = LAMP_GREEN;  end
            SIDE_Y: begin main_light_d = LAMP_RED;    side_light_d = LAMP_YELLOW; end
            PED:    begin main_light_d = LAMP_RED;    side_light_d = LAMP_RED; walk_d = 1'b1; end
            default: begin main_light_d = LAMP_RED;   side_light_d = LAMP_RED;    end
        endcase
    end

    // State, counter, latch and registered lamps; reset wins over tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MAIN_G;
            cnt_q         <= LD_GREEN_MAIN;
            ped_pending_q <= 1'b0;
            main_light_q  <= LAMP_GREEN;
            side_light_q  <= LAMP_RED;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            main_light_q  <= main_light_d;
            side_light_q  <= side_light_d;
            walk_q        <= walk_d;
        end
    end

    assign state      = state_q;
    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign walk       = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
`timescale 1ns/1ps
// Bench for traffic_light_fsm: scenario tasks plus randomized traffic,
// compared against a phase/ticks-remaining reference model.
module tb_traffic_light_fsm;

    localparam int GM = 4;
    localparam int YE = 2;
    localparam int AR = 1;
    localparam int GS = 3;
    localparam int WK = 2;

    logic       clk = 1'b0;
    logic       rst, tick, side_req, ped_req;
    logic [2:0] main_light, side_light, state;
    logic       walk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number and ticks still to serve in that phase.
    int m_state;
    int m_rem;
    bit m_pp;

    traffic_light_fsm #(
        .GREEN_MAIN(GM), .YELLOW(YE), .ALL_RED(AR),
        .GREEN_SIDE(GS), .WALK(WK), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .side_req(side_req), .ped_req(ped_req),
        .main_light(main_light), .side_light(side_light), .walk(walk), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int s);
        case (s)
            0: return GM;
            1: return YE;
            2: return AR;
            3: return GS;
            4: return YE;
            5: return AR;
            default: return WK;
        endcase
    endfunction

    // Expected {state, main, side, walk} for a model phase.
    function automatic logic [9:0] exp_out(input int s);
        logic [2:0] mn, sd;
        mn = (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
        sd = (s == 3) ? 3'b001 : (s == 4) ? 3'b010 : 3'b100;
        return {3'(s), mn, sd, (s == 6)};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit p);
        int nxt;
        bit expire;
        if (r) begin
            m_state = 0; m_rem = GM; m_pp = 1'b0;
        end else begin
            nxt = m_state;
            expire = t && (m_rem == 1);
            if (t && m_rem > 1) m_rem = m_rem - 1;
            if (expire) begin
                case (m_state)
                    0: nxt = (s || m_pp) ? 1 : 0;
                    1: nxt = 2;
                    2: nxt = m_pp ? 6 : 3;
                    6: nxt = s ? 3 : 5;
                    3: nxt = 4;
                    4: nxt = 5;
                    default: nxt = 0;
                endcase
            end
            if (p) m_pp = 1'b1;
            else if (nxt == 6 && m_state != 6) m_pp = 1'b0;
            if (nxt != m_state) m_rem = dur(nxt);
            m_state = nxt;
        end
    endtask

    // Apply one clock of inputs, advance the model, return at the falling edge.
    task automatic clk_cycle(input bit r, input bit t, input bit s, input bit p);
        rst = r; tick = t; side_req = s; ped_req = p;
        @(posedge clk);
        model_step(r, t, s, p);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        clk_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        clk_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        clk_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if ({state, main_light, side_light, walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got=%b exp=%b", {state, main_light, side_light, walk},
                     {3'd0, 3'b001, 3'b100, 1'b0});
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            clk_cycle(1'b0, (k % 10) == 9, 1'b0, 1'b0);
            total++;
            if ({state, main_light, side_light, walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
                bad++;
                $display("FAIL idle k=%0d got=%b exp=%b", k, {state, main_light, side_light, walk},
                         {3'd0, 3'b001, 3'b100, 1'b0});
            end
        end
    endtask

    task automatic test_side_cycle();
        int seq[$];
        int dw[$];
        int exp_seq[7] = '{0, 1, 2, 3, 4, 5, 0};
        int exp_dw[6]  = '{4, 2, 1, 3, 2, 1};
        int ticks_in;
        logic [2:0] prev;
        bit t;
        do_reset();
        seq.push_back(0);
        ticks_in = 0;
        prev = state;
        for (int k = 0; k < 300 && seq.size() < 7; k++) begin
            t = (k % 10) == 9;
            clk_cycle(1'b0, t, 1'b1, 1'b0);
            total++;
            if ({state, main_light, side_light, walk} !== exp_out(m_state)) begin
                bad++;
                $display("FAIL side_cycle k=%0d got=%b exp=%b", k,
                         {state, main_light, side_light, walk}, exp_out(m_state));
            end
            if (t) ticks_in++;
            if (state != prev) begin
                seq.push_back(int'(state));
                dw.push_back(ticks_in);
                ticks_in = 0;
            end
            prev = state;
        end
        total++;
        if (seq.size() != 7) begin
            bad++;
            $display("FAIL side_cycle_len got=%0d exp=7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                total++;
                if (seq[i] != exp_seq[i]) begin
                    bad++;
                    $display("FAIL side_seq[%0d] got=%0d exp=%0d", i, seq[i], exp_seq[i]);
                end
            end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (dw[i] != exp_dw[i]) begin
                    bad++;
                    $display("FAIL side_dwell[%0d] got=%0d exp=%0d", i, dw[i], exp_dw[i]);
                end
            end
        end
    endtask

    task automatic test_ped(input bit side, input int n_exp);
        int seq[$];
        int exp_a[6]  = '{0, 1, 2, 6, 5, 0};
        int exp_b[15] = '{0, 1, 2, 6, 3, 4, 5, 0, 1, 2, 6, 3, 4, 5, 0};
        int walk_ticks;
        int ex;
        bit t, p, second_done;
        logic [2:0] prev;
        do_reset();
        seq.push_back(0);
        walk_ticks = 0;
        second_done = 1'b0;
        prev = state;
        for (int k = 0; k < 600 && seq.size() < n_exp; k++) begin
            t = (k % 10) == 9;
            p = (k == 5);
            if (side && !second_done && m_state == 2 && t) begin
                p = 1'b1;
                second_done = 1'b1;
            end
            clk_cycle(1'b0, t, side, p);
            total++;
            if ({state, main_light, side_light, walk} !== exp_out(m_state)) begin
                bad++;
                $display("FAIL ped k=%0d got=%b exp=%b", k,
                         {state, main_light, side_light, walk}, exp_out(m_state));
            end
            if (prev == 3'd6 && t) walk_ticks++;
            if (state != prev) seq.push_back(int'(state));
            prev = state;
        end
        total++;
        if (seq.size() != n_exp) begin
            bad++;
            $display("FAIL ped_len got=%0d exp=%0d", seq.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                ex = side ? exp_b[i] : exp_a[i];
                total++;
                if (seq[i] != ex) begin
                    bad++;
                    $display("FAIL ped_seq[%0d] got=%0d exp=%0d", i, seq[i], ex);
                end
            end
        end
        total++;
        if (walk_ticks != (side ? 2 * WK : WK)) begin
            bad++;
            $display("FAIL ped_walk_ticks got=%0d exp=%0d", walk_ticks, side ? 2 * WK : WK);
        end
    endtask

    task automatic test_rst_mid();
        int k, ticks;
        bit t, found;
        do_reset();
        found = 1'b0;
        for (k = 0; k < 400 && !found; k++) begin
            t = (k % 10) == 9;
            clk_cycle(1'b0, t, 1'b1, 1'b0);
            if (m_state == 3 && m_rem == 2) found = 1'b1;
        end
        total++;
        if (!found || state !== 3'd3) begin
            bad++;
            $display("FAIL rst_mid_reach got=%0d exp=3", state);
        end
        clk_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if ({state, main_light, side_light, walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_values got=%b exp=%b", {state, main_light, side_light, walk},
                     {3'd0, 3'b001, 3'b100, 1'b0});
        end
        ticks = 0;
        for (int j = 0; j < 100 && state == 3'd0; j++) begin
            t = (j % 10) == 9;
            clk_cycle(1'b0, t, 1'b1, 1'b0);
            if (t) ticks++;
        end
        total++;
        if (ticks != GM || state !== 3'd1) begin
            bad++;
            $display("FAIL rst_mid_reload got=%0d ticks state=%0d exp=%0d ticks state=1",
                     ticks, state, GM);
        end
    endtask

    task automatic test_tick_held();
        logic [2:0] prev;
        int back_at;
        do_reset();
        prev = state;
        back_at = 0;
        for (int c = 1; c <= 20 && back_at == 0; c++) begin
            clk_cycle(1'b0, 1'b1, 1'b1, 1'b0);
            total++;
            if ({state, main_light, side_light, walk} !== exp_out(m_state)) begin
                bad++;
                $display("FAIL tick_held c=%0d got=%b exp=%b", c,
                         {state, main_light, side_light, walk}, exp_out(m_state));
            end
            total++;
            if (main_light[0] && side_light[0]) begin
                bad++;
                $display("FAIL both_green c=%0d got main=%b side=%b", c, main_light, side_light);
            end
            if (state != prev && (state == 3'd0 || state == 3'd3)) begin
                total++;
                if (!(prev == 3'd2 || prev == 3'd5 || prev == 3'd6)) begin
                    bad++;
                    $display("FAIL green_entry c=%0d got prev=%0d exp all-red", c, prev);
                end
            end
            if (c > 4 && state == 3'd0) back_at = c;
            prev = state;
        end
        total++;
        if (back_at != 13) begin
            bad++;
            $display("FAIL tick_held_period got=%0d exp=13", back_at);
        end
    endtask

    task automatic test_random();
        bit r, t, s, p;
        do_reset();
        s = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            t = (k >= 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            p = ($urandom_range(0, 39) == 0);
            clk_cycle(r, t, s, p);
            total++;
            if ({state, main_light, side_light, walk} !== exp_out(m_state)) begin
                bad++;
                $display("FAIL random k=%0d got=%b exp=%b", k,
                         {state, main_light, side_light, walk}, exp_out(m_state));
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; side_req = 1'b0; ped_req = 1'b0;
        m_state = 0; m_rem = GM; m_pp = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_side_cycle();
        test_ped(1'b0, 6);
        test_ped(1'b1, 15);
        test_rst_mid();
        test_tick_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Sequencer for a two-road junction (main road, side road) with a pedestrian crossing. Advances a Moore state machine on the one-cycle tick enable produced by the clock divider, so every phase duration is counted in ticks, never in clock cycles. Drives the main-road and side-road lamp groups and the walk lamp; it is the sole consumer of the divider tick.

## Interface
- `GREEN_MAIN`, 8: minimum main-green duration, in ticks (≥1)
- `YELLOW`, 3: yellow duration for either road, in ticks (≥1)
- `ALL_RED`, 1: all-red clearance duration, in ticks (≥1)
- `GREEN_SIDE`, 5: side-green duration, in ticks (≥1)
- `WALK`, 4: pedestrian walk duration, in ticks (≥1)
- `CNT_W`, 8: phase counter width; every duration must be ≤ 2^CNT_W
- `clk`  in  1  system clock
- `rst`  in  1  reset: synchronous, active-high
- `tick`  in  1  one-cycle enable pulse from the divider
- `side_req`  in  1  side-road vehicle sensor, level, sampled every clock
- `ped_req`  in  1  pedestrian button, any width ≥1 clock, latched
- `main_light`  out  3  {red, yellow, green}, one-hot
- `side_light`  out  3  {red, yellow, green}, one-hot
- `walk`  out  1  walk lamp
- `state`  out  3  current state encoding, for debug and verification

## Operation
- States and encodings: MAIN_G=0, MAIN_Y=1, RED1=2, SIDE_G=3, SIDE_Y=4, RED2=5, PED=6. Encoding 7 is illegal and goes to MAIN_G on the next clock.
- Phase counter `cnt` (CNT_W bits): loaded with duration−1 on every edge that enters a state. On a tick with `cnt`≠0 it decrements. A tick with `cnt`=0 is expiry.
- Transitions; all are taken only on expiry:
  - MAIN_G: stays in MAIN_G (`cnt` holds 0) until side_req=1 or ped_pending=1 is seen together with a tick, then goes to MAIN_Y.
  - MAIN_Y→RED1.
  - RED1→PED if ped_pending, else SIDE_G.
  - PED→SIDE_G if side_req=1, else RED2.
  - SIDE_G→SIDE_Y→RED2→MAIN_G.
- ped_pending: set on any clock with ped_req=1. Cleared on the edge that enters PED. If set and clear occur on the same edge, set wins, so a press during PED entry is served in the next cycle through.
- Lamp decode (Moore, from `state` only):
  - MAIN_G: main 001, side 100
  - MAIN_Y: main 010, side 100
  - SIDE_G: main 100, side 001
  - SIDE_Y: main 100, side 010
  - RED1/RED2/PED: both 100
  - walk=1 only in PED
- Green is never shown on both roads at once; every green is preceded by an all-red state.

## Timing
- Reset values: state=MAIN_G, cnt=GREEN_MAIN−1, ped_pending=0, main_light=001, side_light=100, walk=0.
- rst has priority over tick. Asserting rst mid-phase forces reset values on the next edge. Ticks during rst are ignored, and the first tick after rst release is counted.
- Outputs change on the same edge as `state`: zero latency from the expiry edge, no glitches.
- Dwell in any timed state is exactly its duration in ticks, measured from the entry edge. MAIN_G dwell is ≥GREEN_MAIN ticks.
- Inputs are sampled with no synchronizer; they are assumed synchronous to `clk`.
- When tick is held high continuously, the block must still work, with one count per clock.

## Test plan
Parameters for all scenarios: GREEN_MAIN=4, YELLOW=2, ALL_RED=1, GREEN_SIDE=3, WALK=2; tick every 10 clocks.
- Reset then idle with side_req=0, ped_req=0 for 100 ticks → state stays 0, main_light=001, side_light=100, walk=0 throughout.
- side_req=1 from reset → state sequence 0,1,2,3,4,5,0. Dwells are 4,2,1,3,2,1 ticks. Lamps match the decode at every edge.
- One-clock ped_req pulse at clock 5 with side_req=0 → states 0,1,2,6,5,0. walk=1 for exactly 2 ticks. ped_pending=0 after PED entry.
- ped_req pulse plus side_req=1 → states 0,1,2,6,3,4,5,0. A second ped_req on the PED entry edge yields one more PED visit in the next cycle.
- rst asserted for 1 clock while in SIDE_G with cnt=1 → next edge: state=0, main_light=001, side_light=100, cnt=3.
- tick tied to 1 with side_req=1 → full cycle of 13 clocks. A checker confirms main and side green are never both 1 and any green is preceded by state 2 or 5.
